// File: rtl/arm_fetch_unit.sv
// ----------------------------------------------------------------------------
// arm_fetch_unit
//
// Instruction fetch stage of the ARM core. Holds the PC and fetches one 32-bit
// word per instruction over a level req/ack memory port. The fetched word and
// its decode fields are presented downstream with a valid/ready handshake.
// On the handshake the PC moves to PC+4, or to the word-aligned branch target
// when PCSrc is asserted. An optional ack timeout parks the unit in an error
// state that only reset leaves.
//
// Parameters
//   RESET_PC      PC loaded at reset (bits [1:0] must be 0)
//   MAX_WAIT      ack timeout in cycles, 0 disables the timeout
//
// Ports
//   clk_i         rising-edge clock
//   rst_n_i       asynchronous reset, active low
//   imem_req_o    fetch request, held until ack
//   imem_addr_o   fetch address (the PC)
//   imem_ack_i    read data valid this cycle
//   imem_rdata_i  fetched instruction word
//   inst_valid_o  held instruction and fields are valid
//   inst_ready_i  downstream consumes the instruction this cycle
//   inst_o        held instruction
//   cond_o        inst[31:28]
//   op_o          inst[27:26]
//   funct_o       inst[25:20]
//   pc_plus8_o    PC+8 of the held instruction (R15 read value)
//   PCSrc_i       taken branch, sampled on the handshake only
//   branch_tgt_i  branch target, low two bits ignored
//   fetch_err_o   sticky ack-timeout flag
//
// Optional feature (macro FETCH_PERF_EN)
//   perf_fetched_o  count of handshakes (wraps)
//   perf_stall_o    FETCH cycles without ack plus HOLD cycles without ready
// ----------------------------------------------------------------------------
module arm_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [3:0]  cond_o,
    output logic [1:0]  op_o,
    output logic [5:0]  funct_o,
    output logic [31:0] pc_plus8_o,
    input  logic        PCSrc_i,
    input  logic [31:0] branch_tgt_i,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stall_o,
`endif
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ERR   = 2'd2
    } state_e;

    // Count value at which the next ack-less cycle trips the timeout.
    localparam logic [31:0] WaitLast = (MAX_WAIT == 0) ? 32'd0 : 32'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] waitCnt_q, waitCnt_d;
    logic        reqEn_q;

    logic        handshake;

    assign handshake = (state_q == HOLD) && inst_ready_i;

    // reqEn_q keeps the request low while reset is asserted and until the
    // first clock edge after release, so a late ack from an abandoned fetch
    // cannot be captured.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            waitCnt_q <= '0;
            reqEn_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            waitCnt_q <= waitCnt_d;
            reqEn_q   <= 1'b1;
        end
    end

    // Next-state logic. ERR has no exits; only reset leaves it.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            FETCH: begin
                if (reqEn_q) begin
                    if (imem_ack_i) begin
                        inst_d  = imem_rdata_i;
                        state_d = HOLD;
                    end else if (MAX_WAIT != 0) begin
                        if (waitCnt_q == WaitLast) begin
                            state_d = ERR;
                        end else begin
                            waitCnt_d = waitCnt_q + 32'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (inst_ready_i) begin
                    pc_d      = PCSrc_i ? (branch_tgt_i & 32'hFFFF_FFFC) : (pc_q + 32'd4);
                    waitCnt_d = '0;
                    state_d   = FETCH;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_req_o   = reqEn_q && (state_q == FETCH);
    assign imem_addr_o  = pc_q;
    assign inst_valid_o = (state_q == HOLD);
    assign inst_o       = inst_q;
    assign cond_o       = inst_q[31:28];
    assign op_o         = inst_q[27:26];
    assign funct_o      = inst_q[25:20];
    assign pc_plus8_o   = pc_q + 32'd8;
    assign fetch_err_o  = (state_q == ERR);

`ifdef FETCH_PERF_EN
    logic [31:0] perfFetched_q;
    logic [31:0] perfStall_q;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perfFetched_q <= '0;
            perfStall_q   <= '0;
        end else begin
            if (handshake) begin
                perfFetched_q <= perfFetched_q + 32'd1;
            end
            if ((imem_req_o && !imem_ack_i) || ((state_q == HOLD) && !inst_ready_i)) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o = perfFetched_q;
    assign perf_stall_o   = perfStall_q;
`endif

endmodule

// File: tb/tb_arm_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_arm_fetch_unit
//
// Directed bench for arm_fetch_unit. dutA uses RESET_PC=0 with a 4-cycle ack
// timeout; dutB uses RESET_PC=0xFFFF_FFFC with the timeout disabled, to cover
// PC wrap-around. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_arm_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // dutA signals
    logic        rstA_n = 1'b0;
    logic        ackA = 1'b0, readyA = 1'b0, pcsrcA = 1'b0;
    logic [31:0] rdataA = '0, tgtA = '0;
    logic        reqA, validA, errA;
    logic [31:0] addrA, instA, p8A;
    logic [3:0]  condA;
    logic [1:0]  opA;
    logic [5:0]  functA;

    // dutB signals
    logic        rstB_n = 1'b0;
    logic        ackB = 1'b0, readyB = 1'b0, pcsrcB = 1'b0;
    logic [31:0] rdataB = '0, tgtB = '0;
    logic        reqB, validB, errB;
    logic [31:0] addrB, instB, p8B;
    logic [3:0]  condB;
    logic [1:0]  opB;
    logic [5:0]  functB;

    arm_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dutA (
        .clk_i(clk), .rst_n_i(rstA_n),
        .imem_req_o(reqA), .imem_addr_o(addrA),
        .imem_ack_i(ackA), .imem_rdata_i(rdataA),
        .inst_valid_o(validA), .inst_ready_i(readyA),
        .inst_o(instA), .cond_o(condA), .op_o(opA), .funct_o(functA),
        .pc_plus8_o(p8A), .PCSrc_i(pcsrcA), .branch_tgt_i(tgtA),
        .fetch_err_o(errA)
    );

    arm_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(0)) dutB (
        .clk_i(clk), .rst_n_i(rstB_n),
        .imem_req_o(reqB), .imem_addr_o(addrB),
        .imem_ack_i(ackB), .imem_rdata_i(rdataB),
        .inst_valid_o(validB), .inst_ready_i(readyB),
        .inst_o(instB), .cond_o(condB), .op_o(opB), .funct_o(functB),
        .pc_plus8_o(p8B), .PCSrc_i(pcsrcB), .branch_tgt_i(tgtB),
        .fetch_err_o(errB)
    );

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one full cycle, ending on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // dutA fetch: wait 'delay' cycles without ack, then ack with 'word'.
    task automatic applyStimulus(input string tag, input logic [31:0] expAddr,
                                 input logic [31:0] word, input int delay);
        for (int i = 0; i < delay; i++) begin
            checkOutput({tag, "_wait_req"}, 32'(reqA), 32'd1);
            checkOutput({tag, "_wait_valid"}, 32'(validA), 32'd0);
            tick();
        end
        checkOutput({tag, "_addr"}, addrA, expAddr);
        checkOutput({tag, "_req"}, 32'(reqA), 32'd1);
        ackA   = 1'b1;
        rdataA = word;
        tick();
        ackA   = 1'b0;
        rdataA = 32'h0BAD_0BAD;
        checkOutput({tag, "_valid"}, 32'(validA), 32'd1);
        checkOutput({tag, "_req_low"}, 32'(reqA), 32'd0);
        checkOutput({tag, "_inst"}, instA, word);
        checkOutput({tag, "_cond"}, 32'(condA), 32'(word[31:28]));
        checkOutput({tag, "_op"}, 32'(opA), 32'(word[27:26]));
        checkOutput({tag, "_funct"}, 32'(functA), 32'(word[25:20]));
        checkOutput({tag, "_pc8"}, p8A, expAddr + 32'd8);
    endtask

    // dutA handshake with the given branch decision.
    task automatic handshakeA(input logic pcsrc, input logic [31:0] tgt);
        readyA = 1'b1;
        pcsrcA = pcsrc;
        tgtA   = tgt;
        tick();
        readyA = 1'b0;
        pcsrcA = 1'b0;
        tgtA   = '0;
    endtask

    initial begin
        tick();
        tick();

        // Reset state
        checkOutput("rst_req", 32'(reqA), 32'd0);
        checkOutput("rst_valid", 32'(validA), 32'd0);
        checkOutput("rst_err", 32'(errA), 32'd0);
        checkOutput("rst_inst", instA, 32'd0);
        checkOutput("rst_addr", addrA, 32'h0);

        // Release: request rises on the first edge afterwards
        rstA_n = 1'b1;
        #1;
        checkOutput("rel_req_pre", 32'(reqA), 32'd0);
        tick();
        checkOutput("rel_req_post", 32'(reqA), 32'd1);

        // Sequential fetches, ack after 3 wait cycles
        applyStimulus("f0", 32'h0000_0000, 32'hE3A0_1005, 3);
        handshakeA(1'b0, 32'h0);
        applyStimulus("f4", 32'h0000_0004, 32'hE081_2002, 3);
        handshakeA(1'b0, 32'h0);
        applyStimulus("f8", 32'h0000_0008, 32'h1A00_0003, 0);

        // Branch to 0x40, then taken branch to unaligned 0x103
        handshakeA(1'b1, 32'h0000_0040);
        applyStimulus("f40", 32'h0000_0040, 32'hEA00_002E, 1);
        handshakeA(1'b1, 32'h0000_0103);
        applyStimulus("f100", 32'h0000_0100, 32'hE591_2000, 0);

        // Stalled HOLD: acks and branch inputs must not disturb anything
        for (int i = 0; i < 5; i++) begin
            readyA = 1'b0;
            ackA   = i[0];
            rdataA = 32'hDEAD_BEEF;
            pcsrcA = 1'b1;
            tgtA   = 32'h0000_0800;
            tick();
            checkOutput("stall_inst", instA, 32'hE591_2000);
            checkOutput("stall_cond", 32'(condA), 32'hE);
            checkOutput("stall_op", 32'(opA), 32'h1);
            checkOutput("stall_funct", 32'(functA), 32'h19);
            checkOutput("stall_req", 32'(reqA), 32'd0);
            checkOutput("stall_valid", 32'(validA), 32'd1);
            checkOutput("stall_addr", addrA, 32'h0000_0100);
        end
        ackA = 1'b0;
        handshakeA(1'b0, 32'h0000_0800);
        checkOutput("seq_after_stall", addrA, 32'h0000_0104);

        // Timeout: four ack-less cycles trip the error
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_err_low", 32'(errA), 32'd0);
            checkOutput("to_req_high", 32'(reqA), 32'd1);
            tick();
        end
        checkOutput("to_err", 32'(errA), 32'd1);
        checkOutput("to_req", 32'(reqA), 32'd0);
        checkOutput("to_valid", 32'(validA), 32'd0);
        ackA   = 1'b1;
        readyA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("err_sticky", 32'(errA), 32'd1);
            checkOutput("err_valid", 32'(validA), 32'd0);
            checkOutput("err_req", 32'(reqA), 32'd0);
        end
        ackA   = 1'b0;
        readyA = 1'b0;

        // Reset out of ERR, then reset in the middle of a fetch at 0x20
        rstA_n = 1'b0;
        tick();
        checkOutput("errrst_err", 32'(errA), 32'd0);
        rstA_n = 1'b1;
        tick();
        applyStimulus("r0", 32'h0000_0000, 32'hE1A0_0000, 0);
        handshakeA(1'b1, 32'h0000_0020);
        checkOutput("mid_addr", addrA, 32'h0000_0020);
        tick();
        tick();
        rstA_n = 1'b0;
        #1;
        checkOutput("mid_rst_req", 32'(reqA), 32'd0);
        checkOutput("mid_rst_addr", addrA, 32'h0000_0000);
        ackA   = 1'b1;
        rdataA = 32'h1234_5678;
        tick();
        tick();
        rstA_n = 1'b1;
        #1;
        checkOutput("late_ack_req_pre", 32'(reqA), 32'd0);
        tick();
        checkOutput("late_ack_valid", 32'(validA), 32'd0);
        checkOutput("late_ack_req", 32'(reqA), 32'd1);
        checkOutput("late_ack_inst", instA, 32'd0);
        checkOutput("late_ack_addr", addrA, 32'h0000_0000);
        ackA = 1'b0;
        applyStimulus("r1", 32'h0000_0000, 32'hE280_0001, 1);

        // dutB: wrap-around from 0xFFFF_FFFC, no timeout configured
        rstB_n = 1'b1;
        tick();
        checkOutput("wrap_addr0", addrB, 32'hFFFF_FFFC);
        checkOutput("wrap_pc8_0", p8B, 32'h0000_0004);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("noto_err", 32'(errB), 32'd0);
        checkOutput("noto_req", 32'(reqB), 32'd1);
        ackB   = 1'b1;
        rdataB = 32'hE3A0_0007;
        tick();
        ackB = 1'b0;
        checkOutput("wrap_valid", 32'(validB), 32'd1);
        checkOutput("wrap_inst", instB, 32'hE3A0_0007);
        readyB = 1'b1;
        tick();
        readyB = 1'b0;
        checkOutput("wrap_addr1", addrB, 32'h0000_0000);
        checkOutput("wrap_pc8_1", p8B, 32'h0000_0008);
        checkOutput("wrap_req1", 32'(reqB), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
